// File: rtl/deser_pkg.sv
// Shared types and limits for the deser_n serial-to-parallel deserializer.
package deser_pkg;

  typedef enum logic [1:0] {
    RECEIVE = 2'd0,
    PARITY  = 2'd1,
    WAIT    = 2'd2
  } state_t;

  localparam int MIN_DATA_WIDTH = 2;
  localparam int MAX_DATA_WIDTH = 32;
  localparam int MIN_BUF_DEPTH  = 2;
  localparam int MAX_BUF_DEPTH  = 16;

  // Occupancy needs one extra bit so that "full" is distinct from "empty".
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/deser_fifo.sv
// Synchronous word FIFO for deser_n; head reads as zero while empty.
module deser_fifo
  import deser_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                  clock_100KHZ,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] head
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = count_width(BUF_DEPTH);

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(BUF_DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock_100KHZ) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock_100KHZ) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/deser_n.sv
// Parametrised deserializer with output FIFO; DESER_PARITY_EN adds a trailing
// even-parity bit per word and the parity_err_out pulse.
module deser_n
  import deser_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 2,
  parameter int MSB_FIRST  = 1
) (
  input  logic                  clock_100KHZ,
  input  logic                  reset,
  input  logic                  data_in,
  input  logic                  write_in,
  input  logic                  ack_in,
  output logic                  status_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_ready,
  output logic                  overflow_out
`ifdef DESER_PARITY_EN
  ,
  output logic                  parity_err_out
`endif
);

  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
  localparam bit CFG_OK = (DATA_WIDTH >= MIN_DATA_WIDTH) && (DATA_WIDTH <= MAX_DATA_WIDTH) &&
                          (BUF_DEPTH >= MIN_BUF_DEPTH) && (BUF_DEPTH <= MAX_BUF_DEPTH) &&
                          ((BUF_DEPTH & (BUF_DEPTH - 1)) == 0);

  if (!CFG_OK) begin : g_bad_cfg
    $error("deser_n: unsupported DATA_WIDTH/BUF_DEPTH");
  end

  state_t                state, state_n;
  logic [BW-1:0]         cnt, cnt_n;
  logic [DATA_WIDTH-1:0] shreg, shreg_n, shifted;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  push, full, empty, room;
`ifdef DESER_PARITY_EN
  logic                  perr_n;
`endif

  if (MSB_FIRST != 0) begin : g_msb
    assign shifted = {shreg[DATA_WIDTH-2:0], data_in};
  end else begin : g_lsb
    assign shifted = {data_in, shreg[DATA_WIDTH-1:1]};
  end

  assign room       = !full || (ack_in && !empty);
  assign status_out = (state != WAIT);
  assign data_ready = !empty;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    shreg_n   = shreg;
    push      = 1'b0;
    push_data = shifted;
`ifdef DESER_PARITY_EN
    perr_n    = 1'b0;
`endif
    case (state)
      RECEIVE: begin
        if (write_in) begin
          shreg_n = shifted;
          if (cnt == LAST_BIT) begin
            cnt_n = '0;
`ifdef DESER_PARITY_EN
            state_n = PARITY;
`else
            if (room) push = 1'b1;
            else      state_n = WAIT;
`endif
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
`ifdef DESER_PARITY_EN
      PARITY: begin
        push_data = shreg;
        if (write_in) begin
          if (!(^shreg ^ data_in)) begin
            if (room) begin
              push    = 1'b1;
              state_n = RECEIVE;
            end else begin
              state_n = WAIT;
            end
          end else begin
            perr_n  = 1'b1;
            state_n = RECEIVE;
          end
        end
      end
`endif
      WAIT: begin
        // The FIFO is full here, so ack_in always frees the slot for the held word.
        push_data = shreg;
        if (ack_in) begin
          push    = 1'b1;
          state_n = RECEIVE;
        end
      end
      default: state_n = RECEIVE;
    endcase
  end

  always_ff @(posedge clock_100KHZ) begin
    if (!reset) begin
      state        <= RECEIVE;
      cnt          <= '0;
      shreg        <= '0;
      overflow_out <= 1'b0;
`ifdef DESER_PARITY_EN
      parity_err_out <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      shreg <= shreg_n;
      if (write_in && state == WAIT) overflow_out <= 1'b1;
`ifdef DESER_PARITY_EN
      parity_err_out <= perr_n;
`endif
    end
  end

  deser_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_DEPTH  (BUF_DEPTH)
  ) u_fifo (
    .clock_100KHZ (clock_100KHZ),
    .reset        (reset),
    .push         (push),
    .push_data    (push_data),
    .pop          (ack_in),
    .full         (full),
    .empty        (empty),
    .head         (data_out)
  );

endmodule

// File: tb/tb_deser_n.sv
// Directed self-checking bench for deser_n: an MSB-first and an LSB-first
// instance share one input stream.
module tb_deser_n;

  logic       clock_100KHZ = 1'b0;
  logic       reset    = 1'b0;
  logic       data_in  = 1'b0;
  logic       write_in = 1'b0;
  logic       ack_in   = 1'b0;
  logic       status_out, data_ready, overflow_out;
  logic [7:0] data_out;
  logic       status_l, ready_l, ovf_l;
  logic [7:0] dout_l;
`ifdef DESER_PARITY_EN
  logic       perr, perr_l;
`endif
  int checks = 0;
  int errors = 0;

  always #5 clock_100KHZ = ~clock_100KHZ;

  deser_n #(.DATA_WIDTH(8), .BUF_DEPTH(2), .MSB_FIRST(1)) dut (
    .clock_100KHZ (clock_100KHZ),
    .reset        (reset),
    .data_in      (data_in),
    .write_in     (write_in),
    .ack_in       (ack_in),
    .status_out   (status_out),
    .data_out     (data_out),
    .data_ready   (data_ready),
    .overflow_out (overflow_out)
`ifdef DESER_PARITY_EN
    ,
    .parity_err_out (perr)
`endif
  );

  deser_n #(.DATA_WIDTH(8), .BUF_DEPTH(2), .MSB_FIRST(0)) dut_lsb (
    .clock_100KHZ (clock_100KHZ),
    .reset        (reset),
    .data_in      (data_in),
    .write_in     (write_in),
    .ack_in       (ack_in),
    .status_out   (status_l),
    .data_out     (dout_l),
    .data_ready   (ready_l),
    .overflow_out (ovf_l)
`ifdef DESER_PARITY_EN
    ,
    .parity_err_out (perr_l)
`endif
  );

  task automatic step();
    @(posedge clock_100KHZ);
    #1;
  endtask

  // Bits go out in time order from bits[n-1] down to bits[0].
  task automatic send_bits(input logic [15:0] bits, input int n, input logic ack_last);
    for (int i = n - 1; i >= 0; i--) begin
      data_in  = bits[i];
      write_in = 1'b1;
      ack_in   = (i == 0) ? ack_last : 1'b0;
      step();
    end
    write_in = 1'b0;
    ack_in   = 1'b0;
    data_in  = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input logic ack_last);
`ifdef DESER_PARITY_EN
    send_bits({7'd0, w, ^w}, 9, ack_last);
`else
    send_bits({8'd0, w}, 8, ack_last);
`endif
  endtask

  task automatic pop();
    ack_in = 1'b1;
    step();
    ack_in = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (status_out !== 1'b1) begin errors++; $display("FAIL reset_status got %b want 1", status_out); end
    checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", data_ready); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", data_out); end
    checks++; if (overflow_out !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", overflow_out); end
    checks++; if (ready_l !== 1'b0) begin errors++; $display("FAIL reset_ready_lsb got %b want 0", ready_l); end
`ifdef DESER_PARITY_EN
    checks++; if (perr !== 1'b0) begin errors++; $display("FAIL reset_perr got %b want 0", perr); end
`endif
  endtask

  task automatic test_msb_first();
    send_word(8'hA5, 1'b0);
    checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL msb_ready got %b want 1", data_ready); end
    checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL msb_data got %h want a5", data_out); end
    checks++; if (dout_l !== 8'hA5) begin errors++; $display("FAIL lsb_palindrome got %h want a5", dout_l); end
    pop();
    checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL msb_pop_ready got %b want 0", data_ready); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL msb_pop_data got %h want 00", data_out); end
  endtask

  task automatic test_lsb_first();
    send_word(8'hC0, 1'b0);
    checks++; if (dout_l !== 8'h03) begin errors++; $display("FAIL lsb_data got %h want 03", dout_l); end
    checks++; if (data_out !== 8'hC0) begin errors++; $display("FAIL msb_c0_data got %h want c0", data_out); end
    pop();
    checks++; if (ready_l !== 1'b0) begin errors++; $display("FAIL lsb_pop_ready got %b want 0", ready_l); end
  endtask

  task automatic test_overflow();
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    send_word(8'h33, 1'b0);
    checks++; if (status_out !== 1'b0) begin errors++; $display("FAIL wait_status got %b want 0", status_out); end
    checks++; if (data_out !== 8'h11) begin errors++; $display("FAIL wait_head got %h want 11", data_out); end
    checks++; if (overflow_out !== 1'b0) begin errors++; $display("FAIL wait_ovf_early got %b want 0", overflow_out); end
    data_in  = 1'b1;
    write_in = 1'b1;
    step();
    write_in = 1'b0;
    data_in  = 1'b0;
    checks++; if (overflow_out !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", overflow_out); end
    checks++; if (ovf_l !== 1'b1) begin errors++; $display("FAIL ovf_set_lsb got %b want 1", ovf_l); end
    checks++; if (status_out !== 1'b0) begin errors++; $display("FAIL ovf_status got %b want 0", status_out); end
    pop();
    checks++; if (status_out !== 1'b1) begin errors++; $display("FAIL release_status got %b want 1", status_out); end
    checks++; if (data_out !== 8'h22) begin errors++; $display("FAIL order_2 got %h want 22", data_out); end
    pop();
    checks++; if (data_out !== 8'h33) begin errors++; $display("FAIL order_3 got %h want 33", data_out); end
    pop();
    checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL order_empty got %b want 0", data_ready); end
    checks++; if (overflow_out !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow_out); end
  endtask

  task automatic test_full_ack();
    do_reset();
    send_word(8'h44, 1'b0);
    send_word(8'h55, 1'b0);
    send_word(8'h66, 1'b1);
    checks++; if (status_out !== 1'b1) begin errors++; $display("FAIL fullack_status got %b want 1", status_out); end
    checks++; if (data_out !== 8'h55) begin errors++; $display("FAIL fullack_head got %h want 55", data_out); end
    pop();
    checks++; if (data_out !== 8'h66) begin errors++; $display("FAIL fullack_second got %h want 66", data_out); end
    pop();
    checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL fullack_count got %b want 0", data_ready); end
    checks++; if (overflow_out !== 1'b0) begin errors++; $display("FAIL fullack_ovf got %b want 0", overflow_out); end
  endtask

  task automatic test_reset_mid_word();
    send_word(8'h77, 1'b0);
    send_bits(16'h0016, 5, 1'b0);
    do_reset();
    checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL mid_ready got %b want 0", data_ready); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL mid_data got %h want 00", data_out); end
    checks++; if (status_out !== 1'b1) begin errors++; $display("FAIL mid_status got %b want 1", status_out); end
    send_word(8'h96, 1'b0);
    checks++; if (data_out !== 8'h96) begin errors++; $display("FAIL mid_new_msb got %h want 96", data_out); end
    checks++; if (dout_l !== 8'h69) begin errors++; $display("FAIL mid_new_lsb got %h want 69", dout_l); end
    pop();
  endtask

  task automatic test_back_to_back();
    send_word(8'hA1, 1'b0);
    send_word(8'hB2, 1'b0);
    checks++; if (status_out !== 1'b1) begin errors++; $display("FAIL b2b_status got %b want 1", status_out); end
    checks++; if (data_out !== 8'hA1) begin errors++; $display("FAIL b2b_first got %h want a1", data_out); end
    pop();
    checks++; if (data_out !== 8'hB2) begin errors++; $display("FAIL b2b_second got %h want b2", data_out); end
    pop();
  endtask

`ifdef DESER_PARITY_EN
  task automatic test_parity();
    do_reset();
    send_bits({7'd0, 8'hA5, 1'b0}, 9, 1'b0);
    checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL par_ok_data got %h want a5", data_out); end
    checks++; if (perr !== 1'b0) begin errors++; $display("FAIL par_ok_perr got %b want 0", perr); end
    pop();
    send_bits({7'd0, 8'hA5, 1'b1}, 9, 1'b0);
    checks++; if (perr !== 1'b1) begin errors++; $display("FAIL par_bad_perr got %b want 1", perr); end
    checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL par_bad_ready got %b want 0", data_ready); end
    step();
    checks++; if (perr !== 1'b0) begin errors++; $display("FAIL par_pulse_len got %b want 0", perr); end
  endtask
`endif

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_overflow();
    test_full_ack();
    test_reset_mid_word();
    test_back_to_back();
`ifdef DESER_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
